// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets four requesters share one downstream uart_tx.
// Each grant latches one byte, strobes pi_flag, waits out the frame (plus optional gap) and pulses ack.
module uart_tx_arbiter #(
    parameter int UART_BPS   = 9600,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int GAP_CYCLES = 0
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  ack,
    output logic [7:0]  pi_data,
    output logic        pi_flag,
    output logic        busy,
    output logic [1:0]  grant_id
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int FRAME_CYCLES = 10 * BAUD_CNT_MAX + 4;
    localparam int GAP_LAST_INT = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [23:0] FRAME_LAST = 24'(FRAME_CYCLES - 1);
    localparam logic [23:0] GAP_LAST   = 24'(GAP_LAST_INT);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        GAP,
        DONE
    } state_t;

    state_t      state;
    logic [23:0] frame_cnt;
    logic [23:0] gap_cnt;
    logic [1:0]  last_grant;
    logic [1:0]  winner;
    logic [1:0]  idx;
    logic        found;

    // Search starts one past the last grant and wraps, so every requester gets a turn.
    always_comb begin
        winner = last_grant;
        idx    = last_grant;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            pi_flag    <= 1'b0;
            ack        <= 4'b0000;
            busy       <= 1'b0;
            frame_cnt  <= 24'd0;
            gap_cnt    <= 24'd0;
            pi_data    <= 8'h00;
            grant_id   <= 2'd0;
            last_grant <= 2'd3;
        end else begin
            pi_flag <= 1'b0;
            ack     <= 4'b0000;
            case (state)
                IDLE: begin
                    if (|req) begin
                        pi_data    <= req_data[{winner, 3'b000} +: 8];
                        grant_id   <= winner;
                        last_grant <= winner;
                        busy       <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    pi_flag   <= 1'b1;
                    frame_cnt <= 24'd0;
                    state     <= SEND;
                end
                SEND: begin
                    if (frame_cnt == FRAME_LAST) begin
                        frame_cnt <= 24'd0;
                        gap_cnt   <= 24'd0;
                        state     <= (GAP_CYCLES > 0) ? GAP : DONE;
                    end else begin
                        frame_cnt <= frame_cnt + 24'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= 24'd0;
                        state   <= DONE;
                    end else begin
                        gap_cnt <= gap_cnt + 24'd1;
                    end
                end
                DONE: begin
                    ack   <= 4'b0001 << grant_id;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one DUT without gap and one with a 20-cycle gap.
module tb_uart_tx_arbiter;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [7:0]  pi_data;
    logic        pi_flag;
    logic        busy;
    logic [1:0]  grant_id;

    logic [3:0]  req2;
    logic [31:0] req_data2;
    logic [3:0]  ack2;
    logic [7:0]  pi_data2;
    logic        pi_flag2;
    logic        busy2;
    logic [1:0]  grant_id2;

    int checks;
    int failures;

    uart_tx_arbiter #(
        .UART_BPS  (100_000),
        .CLK_FREQ  (1_000_000),
        .GAP_CYCLES(0)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .pi_data  (pi_data),
        .pi_flag  (pi_flag),
        .busy     (busy),
        .grant_id (grant_id)
    );

    uart_tx_arbiter #(
        .UART_BPS  (100_000),
        .CLK_FREQ  (1_000_000),
        .GAP_CYCLES(20)
    ) dut_gap (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .req      (req2),
        .req_data (req_data2),
        .ack      (ack2),
        .pi_data  (pi_data2),
        .pi_flag  (pi_flag2),
        .busy     (busy2),
        .grant_id (grant_id2)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // Cycles until pi_flag is seen on the no-gap DUT; -1 on timeout.
    task automatic wait_flag(output int n, output bit saw_ack);
        n = -1;
        saw_ack = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            tick(1);
            if (ack !== 4'b0000) saw_ack = 1'b1;
            if (pi_flag === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Cycles until ack is seen; also reports whether pi_data stayed put and pi_flag stayed low.
    task automatic wait_ack(input logic [7:0] exp_data, output int n,
                            output logic [3:0] a, output bit stable);
        n = -1;
        a = 4'b0000;
        stable = 1'b1;
        for (int i = 1; i <= 400; i++) begin
            tick(1);
            if (pi_data !== exp_data || pi_flag !== 1'b0) stable = 1'b0;
            if (ack !== 4'b0000) begin
                n = i;
                a = ack;
                break;
            end
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        req = 4'b0000;
        req2 = 4'b0000;
        tick(3);
        checks++; if (pi_flag !== 1'b0) begin failures++; $display("[TB] FAIL reset_pi_flag got=%b want=0", pi_flag); end
        checks++; if (ack !== 4'b0000) begin failures++; $display("[TB] FAIL reset_ack got=%b want=0000", ack); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        checks++; if (pi_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_pi_data got=%h want=00", pi_data); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("[TB] FAIL reset_grant_id got=%0d want=0", grant_id); end
        sys_rst_n = 1'b1;
        tick(2);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_single();
        int n;
        bit saw;
        bit stable;
        logic [3:0] a;
        req_data = 32'h0000_00A5;
        req = 4'b0001;
        tick(1);
        checks++; if (busy !== 1'b1 || pi_flag !== 1'b0) begin failures++; $display("[TB] FAIL single_load busy=%b pi_flag=%b want busy=1 pi_flag=0", busy, pi_flag); end
        n = 0;
        wait_flag(n, saw);
        n = n + 1;
        checks++; if (n !== 2) begin failures++; $display("[TB] FAIL single_flag_latency got=%0d want=2", n); end
        req = 4'b0000;
        checks++; if (pi_data !== 8'hA5 || grant_id !== 2'd0) begin failures++; $display("[TB] FAIL single_grant pi_data=%h grant_id=%0d want A5/0", pi_data, grant_id); end
        wait_ack(8'hA5, n, a, stable);
        checks++; if (n !== 105) begin failures++; $display("[TB] FAIL single_ack_latency got=%0d want=105", n); end
        checks++; if (a !== 4'b0001) begin failures++; $display("[TB] FAIL single_ack_value got=%b want=0001", a); end
        checks++; if (stable !== 1'b1) begin failures++; $display("[TB] FAIL single_hold got_stable=%b want=1", stable); end
        tick(1);
        checks++; if (ack !== 4'b0000 || busy !== 1'b0) begin failures++; $display("[TB] FAIL single_after_ack ack=%b busy=%b want 0000/0", ack, busy); end
    endtask

    task automatic test_round_robin();
        int n;
        bit saw;
        bit stable;
        logic [3:0] a;
        logic [7:0] bytes [4];
        int order [5];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        sys_rst_n = 1'b0;
        tick(2);
        sys_rst_n = 1'b1;
        req_data = 32'h4433_2211;
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            wait_flag(n, saw);
            checks++; if (n !== 2) begin failures++; $display("[TB] FAIL rr_flag_gap frame=%0d got=%0d want=2", f, n); end
            checks++; if (grant_id !== 2'(order[f]) || pi_data !== bytes[order[f]]) begin failures++; $display("[TB] FAIL rr_grant frame=%0d grant=%0d data=%h want %0d/%h", f, grant_id, pi_data, order[f], bytes[order[f]]); end
            if (f == 4) req = 4'b0000;
            wait_ack(bytes[order[f]], n, a, stable);
            checks++; if (n !== 105 || a !== (4'b0001 << order[f]) || stable !== 1'b1) begin failures++; $display("[TB] FAIL rr_ack frame=%0d lat=%0d ack=%b stable=%b want 105/%b/1", f, n, a, stable, 4'b0001 << order[f]); end
        end
        tick(3);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rr_idle busy=%b want=0", busy); end
    endtask

    task automatic test_deassert();
        int n;
        bit saw;
        bit stable;
        logic [3:0] a;
        req_data = 32'h003C_0000;
        req = 4'b0100;
        wait_flag(n, saw);
        checks++; if (grant_id !== 2'd2 || pi_data !== 8'h3C) begin failures++; $display("[TB] FAIL deassert_grant grant=%0d data=%h want 2/3C", grant_id, pi_data); end
        tick(10);
        req = 4'b0000;
        req_data = 32'hFFFF_FFFF;
        wait_ack(8'h3C, n, a, stable);
        checks++; if (n + 10 !== 105 || a !== 4'b0100) begin failures++; $display("[TB] FAIL deassert_ack lat=%0d ack=%b want 105/0100", n + 10, a); end
        checks++; if (stable !== 1'b1) begin failures++; $display("[TB] FAIL data_change_hold stable=%b want=1", stable); end
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (ack !== 4'b0000 || busy !== 1'b0) n++;
        end
        checks++; if (n !== 0) begin failures++; $display("[TB] FAIL deassert_single_ack extra_cycles=%0d want=0", n); end
    endtask

    task automatic test_reset_mid();
        int n;
        bit saw;
        bit stable;
        logic [3:0] a;
        req_data = 32'h7700_0055;
        req = 4'b1001;
        wait_flag(n, saw);
        checks++; if (grant_id !== 2'd3 || pi_data !== 8'h77) begin failures++; $display("[TB] FAIL midrst_first_grant grant=%0d data=%h want 3/77", grant_id, pi_data); end
        tick(50);
        sys_rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || pi_flag !== 1'b0 || ack !== 4'b0000 || pi_data !== 8'h00 || grant_id !== 2'd0) begin failures++; $display("[TB] FAIL midrst_outputs busy=%b flag=%b ack=%b data=%h grant=%0d want all zero", busy, pi_flag, ack, pi_data, grant_id); end
        tick(2);
        sys_rst_n = 1'b1;
        wait_flag(n, saw);
        checks++; if (n !== 2 || saw !== 1'b0) begin failures++; $display("[TB] FAIL midrst_regrant lat=%0d saw_ack=%b want 2/0", n, saw); end
        checks++; if (grant_id !== 2'd0 || pi_data !== 8'h55) begin failures++; $display("[TB] FAIL midrst_priority grant=%0d data=%h want 0/55", grant_id, pi_data); end
        req = 4'b0000;
        wait_ack(8'h55, n, a, stable);
        checks++; if (n !== 105 || a !== 4'b0001) begin failures++; $display("[TB] FAIL midrst_ack lat=%0d ack=%b want 105/0001", n, a); end
    endtask

    task automatic test_gap();
        int n;
        int ack_at;
        int flag_at;
        logic [3:0] ack_seen;
        logic [1:0] first_grant;
        req_data2 = 32'h0000_3412;
        req2 = 4'b0011;
        n = -1;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (pi_flag2 === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++; if (n !== 2) begin failures++; $display("[TB] FAIL gap_first_flag lat=%0d want=2", n); end
        first_grant = grant_id2;
        checks++; if (first_grant !== 2'd0 || pi_data2 !== 8'h12) begin failures++; $display("[TB] FAIL gap_first_grant grant=%0d data=%h want 0/12", first_grant, pi_data2); end
        ack_at = -1;
        flag_at = -1;
        ack_seen = 4'b0000;
        for (int i = 1; i <= 300; i++) begin
            tick(1);
            if (ack2 !== 4'b0000 && ack_at < 0) begin
                ack_at = i;
                ack_seen = ack2;
            end
            if (pi_flag2 === 1'b1) begin
                flag_at = i;
                break;
            end
        end
        req2 = 4'b0000;
        checks++; if (ack_at !== 125 || ack_seen !== 4'b0001) begin failures++; $display("[TB] FAIL gap_ack lat=%0d ack=%b want 125/0001", ack_at, ack_seen); end
        checks++; if (flag_at !== 127) begin failures++; $display("[TB] FAIL gap_flag_spacing got=%0d want=127", flag_at); end
        checks++; if (grant_id2 !== 2'd1 || pi_data2 !== 8'h34) begin failures++; $display("[TB] FAIL gap_second_grant grant=%0d data=%h want 1/34", grant_id2, pi_data2); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        sys_rst_n = 1'b0;
        req = 4'b0000;
        req_data = 32'h0;
        req2 = 4'b0000;
        req_data2 = 32'h0;
        test_reset();
        test_single();
        test_round_robin();
        test_deassert();
        test_reset_mid();
        test_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
